// File: rtl/stack_controller_pkg.sv
// Shared constants, state encoding and small helpers for the stack game sequencer.
package stack_controller_pkg;

  localparam logic [7:0] X_MAX     = 8'd144;
  localparam logic [7:0] INIT_W    = 8'd16;
  localparam logic [7:0] BASE_X    = 8'd72;
  localparam logic [3:0] LEVEL_MAX = 4'd15;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_LOAD  = 4'd1,
    ST_MOVE  = 4'd2,
    ST_LATCH = 4'd3,
    ST_CHECK = 4'd4,
    ST_DRAW  = 4'd5,
    ST_NEXT  = 4'd6,
    ST_OVER  = 4'd7,
    ST_WIN   = 4'd8
  } state_t;

  // Even levels launch from the left edge moving right, odd levels from the right edge moving left.
  function automatic logic [7:0] start_x(input logic [3:0] lvl);
    return lvl[0] ? X_MAX : 8'd0;
  endfunction

  function automatic logic start_dir(input logic [3:0] lvl);
    return lvl[0] ? DIR_LEFT : DIR_RIGHT;
  endfunction

endpackage

// File: rtl/stack_controller_if.sv
// Signal bundle between the sequencer and its neighbours (keys, x register, draw FSM).
interface stack_controller_if;
  logic       start;
  logic       drop;
  logic [7:0] curr_x;
  logic       draw_done;
  logic       load_x;
  logic [7:0] new_x;
  logic       new_dir;
  logic       shift_en;
  logic       draw_req;
  logic [7:0] draw_x;
  logic [7:0] draw_w;
  logic [3:0] level;
  logic       game_over;
  logic       win;

  modport master (
    input  start, drop, curr_x, draw_done,
    output load_x, new_x, new_dir, shift_en, draw_req, draw_x, draw_w, level, game_over, win
  );

  modport slave (
    output start, drop, curr_x, draw_done,
    input  load_x, new_x, new_dir, shift_en, draw_req, draw_x, draw_w, level, game_over, win
  );
endinterface

// File: rtl/stack_controller_overlap_calc.sv
// Combinational overlap of the dropped block with the block below, evaluated at 9 bits
// so that x + width never wraps.
module overlap_calc (
  input  logic [7:0] cap_x,
  input  logic [7:0] cur_w,
  input  logic [7:0] prev_x,
  input  logic [7:0] prev_w,
  output logic [7:0] left_x,
  output logic [7:0] width,
  output logic       hit
);
  logic [8:0] cap_r;
  logic [8:0] prev_r;
  logic [8:0] right_x;

  // Intersection [max(left edges), min(right edges)); empty when right <= left.
  always_comb begin
    cap_r   = {1'b0, cap_x} + {1'b0, cur_w};
    prev_r  = {1'b0, prev_x} + {1'b0, prev_w};
    left_x  = (cap_x > prev_x) ? cap_x : prev_x;
    right_x = (cap_r < prev_r) ? cap_r : prev_r;
    hit     = right_x > {1'b0, left_x};
    width   = 8'(right_x - {1'b0, left_x});
  end
endmodule

// File: rtl/stack_controller.sv
// Game sequencer: launches each block, freezes it on drop, trims it to the overlap,
// requests a redraw and advances the level or ends the game.
module stack_controller
  import stack_controller_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  stack_controller_if.master bus
);
  state_t     state_reg;
  logic [7:0] cap_x_reg;
  logic [7:0] prev_x_reg;
  logic [7:0] prev_w_reg;
  logic [7:0] cur_w_reg;
  logic [3:0] level_reg;
  logic       load_x_reg;
  logic [7:0] new_x_reg;
  logic       new_dir_reg;
  logic       shift_en_reg;
  logic       draw_req_reg;
  logic [7:0] draw_x_reg;
  logic [7:0] draw_w_reg;
  logic       game_over_reg;
  logic       win_reg;

  logic [7:0] ovl_left;
  logic [7:0] ovl_width;
  logic       ovl_hit;
  logic [3:0] level_inc;

  assign level_inc = level_reg + 4'd1;

  overlap_calc u_overlap (
    .cap_x  (cap_x_reg),
    .cur_w  (cur_w_reg),
    .prev_x (prev_x_reg),
    .prev_w (prev_w_reg),
    .left_x (ovl_left),
    .width  (ovl_width),
    .hit    (ovl_hit)
  );

  // Sequencer FSM with all outputs registered; load_x is a one-cycle pulse that coincides with LOAD.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg     <= ST_IDLE;
      cap_x_reg     <= 8'd0;
      prev_x_reg    <= BASE_X;
      prev_w_reg    <= INIT_W;
      cur_w_reg     <= INIT_W;
      level_reg     <= 4'd0;
      load_x_reg    <= 1'b0;
      new_x_reg     <= 8'd0;
      new_dir_reg   <= DIR_RIGHT;
      shift_en_reg  <= 1'b0;
      draw_req_reg  <= 1'b0;
      draw_x_reg    <= 8'd0;
      draw_w_reg    <= 8'd0;
      game_over_reg <= 1'b0;
      win_reg       <= 1'b0;
    end else begin
      load_x_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            load_x_reg  <= 1'b1;
            new_x_reg   <= start_x(4'd0);
            new_dir_reg <= start_dir(4'd0);
            state_reg   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          shift_en_reg <= 1'b1;
          state_reg    <= ST_MOVE;
        end
        ST_MOVE: begin
          // start is not a valid request here; only drop matters, so drop wins a tie.
          if (bus.drop) begin
            shift_en_reg <= 1'b0;
            state_reg    <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          cap_x_reg <= bus.curr_x;
          state_reg <= ST_CHECK;
        end
        ST_CHECK: begin
          if (ovl_hit) begin
            prev_x_reg   <= ovl_left;
            prev_w_reg   <= ovl_width;
            cur_w_reg    <= ovl_width;
            draw_x_reg   <= ovl_left;
            draw_w_reg   <= ovl_width;
            draw_req_reg <= 1'b1;
            state_reg    <= ST_DRAW;
          end else begin
            game_over_reg <= 1'b1;
            state_reg     <= ST_OVER;
          end
        end
        ST_DRAW: begin
          if (bus.draw_done) begin
            draw_req_reg <= 1'b0;
            state_reg    <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          level_reg <= level_inc;
          if (level_inc == LEVEL_MAX) begin
            win_reg   <= 1'b1;
            state_reg <= ST_WIN;
          end else begin
            load_x_reg  <= 1'b1;
            new_x_reg   <= start_x(level_inc);
            new_dir_reg <= start_dir(level_inc);
            state_reg   <= ST_LOAD;
          end
        end
        ST_OVER, ST_WIN: begin
          if (bus.start) begin
            prev_x_reg    <= BASE_X;
            prev_w_reg    <= INIT_W;
            cur_w_reg     <= INIT_W;
            level_reg     <= 4'd0;
            game_over_reg <= 1'b0;
            win_reg       <= 1'b0;
            load_x_reg    <= 1'b1;
            new_x_reg     <= start_x(4'd0);
            new_dir_reg   <= start_dir(4'd0);
            state_reg     <= ST_LOAD;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.load_x    = load_x_reg;
  assign bus.new_x     = new_x_reg;
  assign bus.new_dir   = new_dir_reg;
  assign bus.shift_en  = shift_en_reg;
  assign bus.draw_req  = draw_req_reg;
  assign bus.draw_x    = draw_x_reg;
  assign bus.draw_w    = draw_w_reg;
  assign bus.level     = level_reg;
  assign bus.game_over = game_over_reg;
  assign bus.win       = win_reg;
endmodule

// File: tb/tb_stack_controller.sv
// Self-checking bench for stack_controller: a table of single-drop games plus
// hand-written multi-level sequences, with drop outcomes tracked through a scoreboard.
module tb_stack_controller;
  logic clk = 1'b0;
  logic resetn = 1'b0;

  stack_controller_if bus();

  stack_controller dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       hit;
    logic [7:0] x;
    logic [7:0] w;
  } result_t;

  typedef struct packed {
    logic [7:0] drop_x;
    logic       with_start;
    logic       hit;
    logic [7:0] x;
    logic [7:0] w;
  } vec_t;

  result_t sb_q[$];
  vec_t    vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn        = 1'b0;
    bus.start     = 1'b0;
    bus.drop      = 1'b0;
    bus.draw_done = 1'b0;
    bus.curr_x    = 8'd0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  // Pulse start from an idle/ended state and check the load pulse, then the MOVE cycle.
  task automatic start_game(input logic [7:0] exp_x, input logic exp_dir);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("start_load_x", 32'(bus.load_x), 32'd1);
    check("start_new_x", 32'(bus.new_x), 32'(exp_x));
    check("start_new_dir", 32'(bus.new_dir), 32'(exp_dir));
    check("start_level", 32'(bus.level), 32'd0);
    tick();
    check("move_shift_en", 32'(bus.shift_en), 32'd1);
    check("move_load_x", 32'(bus.load_x), 32'd0);
  endtask

  // Drop at x (optionally with a simultaneous start), wait for DRAW or OVER and score it.
  task automatic drop_block(input logic [7:0] x, input logic with_start, input result_t exp);
    result_t got_exp;
    bit      seen;
    sb_q.push_back(exp);
    bus.curr_x = x;
    bus.drop   = 1'b1;
    bus.start  = with_start;
    tick();
    bus.drop  = 1'b0;
    bus.start = 1'b0;
    check("drop_shift_off", 32'(bus.shift_en), 32'd0);
    check("drop_no_load", 32'(bus.load_x), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (bus.draw_req || bus.game_over) seen = 1'b1;
    end
    if (!seen) check("resolve_timeout", 32'd0, 32'd1);
    got_exp = sb_q.pop_front();
    check("drop_hit", 32'(bus.draw_req), 32'(got_exp.hit));
    check("drop_game_over", 32'(bus.game_over), 32'(!got_exp.hit));
    if (got_exp.hit) begin
      check("draw_x", 32'(bus.draw_x), 32'(got_exp.x));
      check("draw_w", 32'(bus.draw_w), 32'(got_exp.w));
    end
    $display("drop x=%0d start=%0d -> draw_req=%0d draw_x=%0d draw_w=%0d game_over=%0d level=%0d",
             x, with_start, bus.draw_req, bus.draw_x, bus.draw_w, bus.game_over, bus.level);
  endtask

  // Finish a draw and check the level update plus the following launch (or the win).
  task automatic finish_draw(input logic [3:0] exp_level);
    bus.draw_done = 1'b1;
    tick();
    bus.draw_done = 1'b0;
    check("done_draw_req", 32'(bus.draw_req), 32'd0);
    tick();
    check("next_level", 32'(bus.level), 32'(exp_level));
    if (exp_level == 4'd15) begin
      check("win_flag", 32'(bus.win), 32'd1);
      check("win_no_load", 32'(bus.load_x), 32'd0);
    end else begin
      check("next_load_x", 32'(bus.load_x), 32'd1);
      check("next_new_x", 32'(bus.new_x), exp_level[0] ? 32'd144 : 32'd0);
      check("next_new_dir", 32'(bus.new_dir), exp_level[0] ? 32'd0 : 32'd1);
      tick();
      check("next_shift_en", 32'(bus.shift_en), 32'd1);
    end
  endtask

  initial begin
    result_t r;

    // drop_x, with_start, hit, draw_x, draw_w -- each from a fresh game over prev (72,16)
    vecs[0]  = '{8'd72,  1'b0, 1'b1, 8'd72, 8'd16};
    vecs[1]  = '{8'd80,  1'b0, 1'b1, 8'd80, 8'd8};
    vecs[2]  = '{8'd64,  1'b0, 1'b1, 8'd72, 8'd8};
    vecs[3]  = '{8'd57,  1'b0, 1'b1, 8'd72, 8'd1};
    vecs[4]  = '{8'd87,  1'b0, 1'b1, 8'd87, 8'd1};
    vecs[5]  = '{8'd56,  1'b0, 1'b0, 8'd0,  8'd0};
    vecs[6]  = '{8'd88,  1'b0, 1'b0, 8'd0,  8'd0};
    vecs[7]  = '{8'd100, 1'b0, 1'b0, 8'd0,  8'd0};
    vecs[8]  = '{8'd0,   1'b0, 1'b0, 8'd0,  8'd0};
    vecs[9]  = '{8'd144, 1'b0, 1'b0, 8'd0,  8'd0};
    vecs[10] = '{8'd250, 1'b0, 1'b0, 8'd0,  8'd0};
    vecs[11] = '{8'd72,  1'b1, 1'b1, 8'd72, 8'd16};

    // Reset state
    do_reset();
    check("rst_load_x", 32'(bus.load_x), 32'd0);
    check("rst_shift_en", 32'(bus.shift_en), 32'd0);
    check("rst_draw_req", 32'(bus.draw_req), 32'd0);
    check("rst_new_x", 32'(bus.new_x), 32'd0);
    check("rst_new_dir", 32'(bus.new_dir), 32'd1);
    check("rst_level", 32'(bus.level), 32'd0);
    check("rst_game_over", 32'(bus.game_over), 32'd0);
    check("rst_win", 32'(bus.win), 32'd0);

    // Table: one drop per fresh game
    for (int i = 0; i < 12; i++) begin
      do_reset();
      start_game(8'd0, 1'b1);
      r = '{vecs[i].hit, vecs[i].x, vecs[i].w};
      drop_block(vecs[i].drop_x, vecs[i].with_start, r);
      if (vecs[i].hit) begin
        finish_draw(4'd1);
      end else begin
        tick();
        tick();
        check("over_held", 32'(bus.game_over), 32'd1);
        check("over_no_draw", 32'(bus.draw_req), 32'd0);
        check("over_no_load", 32'(bus.load_x), 32'd0);
      end
    end

    // Multi-level game: start ignored in MOVE, narrowing blocks, then a miss
    do_reset();
    start_game(8'd0, 1'b1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("move_start_ignored_load", 32'(bus.load_x), 32'd0);
    check("move_start_ignored_shift", 32'(bus.shift_en), 32'd1);
    bus.draw_done = 1'b1;
    tick();
    bus.draw_done = 1'b0;
    check("move_done_ignored", 32'(bus.shift_en), 32'd1);
    drop_block(8'd72, 1'b0, '{1'b1, 8'd72, 8'd16});
    finish_draw(4'd1);
    drop_block(8'd80, 1'b0, '{1'b1, 8'd80, 8'd8});
    finish_draw(4'd2);
    drop_block(8'd76, 1'b0, '{1'b1, 8'd80, 8'd4});
    finish_draw(4'd3);
    drop_block(8'd100, 1'b0, '{1'b0, 8'd0, 8'd0});
    check("over_level_kept", 32'(bus.level), 32'd3);

    // Restart from OVER restores base block and width, then play to a win
    start_game(8'd0, 1'b1);
    check("restart_game_over_clr", 32'(bus.game_over), 32'd0);
    for (int i = 1; i <= 15; i++) begin
      drop_block(8'd72, 1'b0, '{1'b1, 8'd72, 8'd16});
      finish_draw(4'(i));
    end

    // Drop and draw_done are ignored after a win
    bus.curr_x = 8'd72;
    bus.drop   = 1'b1;
    tick();
    bus.drop = 1'b0;
    tick();
    tick();
    tick();
    check("win_drop_ignored", 32'(bus.draw_req), 32'd0);
    check("win_held", 32'(bus.win), 32'd1);
    check("win_no_shift", 32'(bus.shift_en), 32'd0);
    bus.draw_done = 1'b1;
    tick();
    bus.draw_done = 1'b0;
    check("win_done_ignored", 32'(bus.level), 32'd15);
    start_game(8'd0, 1'b1);
    check("restart_win_clr", 32'(bus.win), 32'd0);

    // Reset while in DRAW aborts on the next edge
    drop_block(8'd72, 1'b0, '{1'b1, 8'd72, 8'd16});
    finish_draw(4'd1);
    drop_block(8'd72, 1'b0, '{1'b1, 8'd72, 8'd16});
    resetn = 1'b0;
    tick();
    check("abort_draw_req", 32'(bus.draw_req), 32'd0);
    check("abort_shift_en", 32'(bus.shift_en), 32'd0);
    check("abort_level", 32'(bus.level), 32'd0);
    resetn = 1'b1;
    bus.draw_done = 1'b1;
    tick();
    bus.draw_done = 1'b0;
    tick();
    tick();
    check("post_rst_done_level", 32'(bus.level), 32'd0);
    check("post_rst_done_load", 32'(bus.load_x), 32'd0);
    check("post_rst_done_draw", 32'(bus.draw_req), 32'd0);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
